// File: rtl/hood_pkg.sv
// Shared state encoding, default timing constants and a small sizing helper
// for the range-hood mode controller.
package hood_pkg;

  typedef enum logic [2:0] {
    StOff      = 3'd0,
    StStandby  = 3'd1,
    StRun      = 3'd2,
    StBoost    = 3'd3,
    StClean    = 3'd4,
    StCooldown = 3'd5
  } hood_state_e;

  localparam int unsigned DefClkHz       = 100_000_000;
  localparam int unsigned DefNumLevels   = 4;
  localparam int unsigned DefBoostSec    = 60;
  localparam int unsigned DefCleanSec    = 180;
  localparam int unsigned DefOffDelaySec = 90;
  localparam int unsigned DefGestureSec  = 5;

  function automatic int unsigned max4(input int unsigned a, input int unsigned b,
                                       input int unsigned c, input int unsigned d);
    int unsigned m;
    m = a;
    if (b > m) m = b;
    if (c > m) m = c;
    if (d > m) m = d;
    return m;
  endfunction

endpackage

// File: rtl/hood_sec_tick.sv
// One-pulse-per-second strobe: o_tick is high on the last of every CLK_HZ cycles.
// i_restart zeroes the phase so the next tick lands exactly CLK_HZ cycles later.
module hood_sec_tick
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ = DefClkHz
) (
  input  logic i_clk,
  input  logic i_reset,
  input  logic i_restart,
  output logic o_tick
);

  localparam int unsigned CntW = (CLK_HZ > 1) ? $clog2(CLK_HZ) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HZ - 1);

  logic [CntW-1:0] r_cnt_q, r_cnt_d;

  assign o_tick = (r_cnt_q == CntLast);

  always_comb begin
    r_cnt_d = r_cnt_q + CntW'(1);
    if (i_restart || o_tick) r_cnt_d = '0;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) r_cnt_q <= '0;
    else         r_cnt_q <= r_cnt_d;
  end

endmodule

// File: rtl/hood_mode_ctrl.sv
// Range-hood mode controller: power/run/boost/self-clean/cooldown FSM with second countdowns.
// Define HOOD_GESTURE_EN to add the left-then-right hand-wave power gesture.
module hood_mode_ctrl
  import hood_pkg::*;
#(
  parameter int unsigned CLK_HZ        = DefClkHz,
  parameter int unsigned NUM_LEVELS    = DefNumLevels,
  parameter int unsigned BOOST_SEC     = DefBoostSec,
  parameter int unsigned CLEAN_SEC     = DefCleanSec,
  parameter int unsigned OFF_DELAY_SEC = DefOffDelaySec,
  parameter int unsigned GESTURE_SEC   = DefGestureSec,
  localparam int unsigned LW = $clog2(NUM_LEVELS),
  localparam int unsigned CW = $clog2(max4(BOOST_SEC, CLEAN_SEC, OFF_DELAY_SEC, GESTURE_SEC) + 1)
) (
  input  logic          clk,
  input  logic          reset,
  input  logic          btn_power,
  input  logic          btn_boost,
  input  logic          btn_clean,
  input  logic          lvl_vld,
  input  logic [LW-1:0] lvl_req,
  input  logic          hand_l,
  input  logic          hand_r,
  output logic          power_on,
  output logic [2:0]    state,
  output logic [LW-1:0] fan_level,
  output logic [CW-1:0] countdown,
  output logic          boost_used,
  output logic          gesture_armed
);

  localparam logic [LW-1:0] LvlFull   = LW'(NUM_LEVELS - 1);
  localparam logic [LW-1:0] LvlRunMax = LW'(NUM_LEVELS - 2);
  localparam logic [CW-1:0] CntBoost  = CW'(BOOST_SEC);
  localparam logic [CW-1:0] CntClean  = CW'(CLEAN_SEC);
  localparam logic [CW-1:0] CntOff    = CW'(OFF_DELAY_SEC);

  hood_state_e   r_state_q, r_state_d;
  logic [LW-1:0] r_fan_q, r_fan_d;
  logic [CW-1:0] r_cnt_q, r_cnt_d;
  logic          r_used_q, r_used_d;
  logic          w_restart, w_tick, w_power, w_lvl_run;

  hood_sec_tick #(.CLK_HZ(CLK_HZ)) u_sec_tick (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_restart(w_restart),
    .o_tick   (w_tick)
  );

`ifdef HOOD_GESTURE_EN
  localparam logic [CW-1:0] CntGesture = CW'(GESTURE_SEC);

  logic          r_armed_q, r_armed_d;
  logic [CW-1:0] r_gcnt_q, r_gcnt_d;
  logic          w_gtick, w_hand_fire;

  assign w_hand_fire = hand_r & r_armed_q;

  hood_sec_tick #(.CLK_HZ(CLK_HZ)) u_gest_tick (
    .i_clk    (clk),
    .i_reset  (reset),
    .i_restart(hand_l),
    .o_tick   (w_gtick)
  );

  always_comb begin
    r_armed_d = r_armed_q;
    r_gcnt_d  = r_gcnt_q;
    if (w_hand_fire) begin
      r_armed_d = 1'b0;
      r_gcnt_d  = '0;
    end else if (hand_l) begin
      r_armed_d = 1'b1;
      r_gcnt_d  = CntGesture;
    end else if (r_armed_q && w_gtick) begin
      if (r_gcnt_q == CW'(1)) begin
        r_armed_d = 1'b0;
        r_gcnt_d  = '0;
      end else begin
        r_gcnt_d = r_gcnt_q - CW'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_armed_q <= 1'b0;
      r_gcnt_q  <= '0;
    end else begin
      r_armed_q <= r_armed_d;
      r_gcnt_q  <= r_gcnt_d;
    end
  end

  assign gesture_armed = r_armed_q;
  assign w_power       = btn_power | w_hand_fire;
`else
  logic w_unused_hand;
  assign w_unused_hand = hand_l ^ hand_r;
  assign gesture_armed = 1'b0;
  assign w_power       = btn_power;
`endif

  assign w_lvl_run = (lvl_req != '0) && (lvl_req <= LvlRunMax);

  always_comb begin
    r_state_d = r_state_q;
    r_fan_d   = r_fan_q;
    r_cnt_d   = r_cnt_q;
    r_used_d  = r_used_q;
    w_restart = 1'b0;
    unique case (r_state_q)
      StOff: if (w_power) r_state_d = StStandby;
      StStandby, StRun: begin
        // Strict priority: a higher event present in the cycle discards the lower ones.
        if (w_power) begin
          if (r_state_q == StStandby) begin
            r_state_d = StOff;
          end else begin
            r_state_d = StCooldown;
            r_cnt_d   = CntOff;
            w_restart = 1'b1;
          end
        end else if (btn_clean) begin
          if (r_state_q == StStandby) begin
            r_state_d = StClean;
            r_fan_d   = LvlFull;
            r_cnt_d   = CntClean;
            w_restart = 1'b1;
          end
        end else if (btn_boost) begin
          if (!r_used_q) begin
            r_state_d = StBoost;
            r_fan_d   = LvlFull;
            r_cnt_d   = CntBoost;
            r_used_d  = 1'b1;
            w_restart = 1'b1;
          end
        end else if (lvl_vld) begin
          if (lvl_req == '0) begin
            r_state_d = StStandby;
          end else if (w_lvl_run) begin
            r_state_d = StRun;
            r_fan_d   = lvl_req;
          end
        end
      end
      StBoost, StClean, StCooldown: begin
        if (w_power) begin
          unique case (r_state_q)
            StBoost: begin
              r_state_d = StCooldown;
              r_cnt_d   = CntOff;
              w_restart = 1'b1;
            end
            StClean: r_state_d = StOff;
            default: r_state_d = StStandby;
          endcase
        end else if (w_tick) begin
          if (r_cnt_q == CW'(1)) begin
            r_state_d = (r_state_q == StCooldown) ? StOff : StStandby;
          end else begin
            r_cnt_d = r_cnt_q - CW'(1);
          end
        end
      end
      default: r_state_d = StOff;
    endcase
    // Idle states never carry a fan level or a countdown.
    if (r_state_d == StOff || r_state_d == StStandby) begin
      r_fan_d = '0;
      r_cnt_d = '0;
    end
    if (r_state_d == StOff) r_used_d = 1'b0;
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      r_state_q <= StOff;
      r_fan_q   <= '0;
      r_cnt_q   <= '0;
      r_used_q  <= 1'b0;
    end else begin
      r_state_q <= r_state_d;
      r_fan_q   <= r_fan_d;
      r_cnt_q   <= r_cnt_d;
      r_used_q  <= r_used_d;
    end
  end

  assign power_on   = (r_state_q != StOff);
  assign state      = r_state_q;
  assign fan_level  = r_fan_q;
  assign countdown  = r_cnt_q;
  assign boost_used = r_used_q;

endmodule
